// File: rtl/mc_core_pkg.sv
// Shared states, opcodes, ALU controls and mux selects for the mc_core multi-cycle MIPS core.
// Defining MC_CORE_EXT_EN adds the addi/bne/j extension states.
package mc_core_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXEC,
    ALUWB,
    BRANCH,
    HALT
`ifdef MC_CORE_EXT_EN
    ,
    ADDIEX,
    ADDIWB,
    JUMP
`endif
  } state_t;

  typedef enum logic [2:0] {
    ALU_AND,
    ALU_OR,
    ALU_ADD,
    ALU_SUB,
    ALU_SLT
  } alu_ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic       ALUSRCA_PC     = 1'b0;
  localparam logic       ALUSRCA_A      = 1'b1;
  localparam logic [1:0] ALUSRCB_B      = 2'd0;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'd1;
  localparam logic [1:0] ALUSRCB_IMM    = 2'd2;
  localparam logic [1:0] ALUSRCB_IMMSL2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  function automatic logic funct_legal(input logic [5:0] funct);
    return funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
  endfunction

  function automatic alu_ctrl_t funct_alu(input logic [5:0] funct);
    case (funct)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_core_ctrl.sv
// Control FSM and instruction decode for mc_core; emits mux selects, enables and the memory handshake.
// Defining MC_CORE_EXT_EN adds addi, bne and j decoding.
module mc_core_ctrl
  import mc_core_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_en,
  output logic       pc_en,
  output logic       ab_en,
  output logic       aluout_en,
  output logic       data_en,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [1:0] pc_src,
  output logic       alu_srca,
  output logic [1:0] alu_srcb,
  output alu_ctrl_t  alu_ctrl,
  output logic       retire,
  output logic       halted
);

  state_t state, next_state;
  logic   req, we;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    req        = 1'b0;
    we         = 1'b0;
    iord       = 1'b0;
    ir_en      = 1'b0;
    pc_en      = 1'b0;
    ab_en      = 1'b0;
    aluout_en  = 1'b0;
    data_en    = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    pc_src     = PCSRC_ALU;
    alu_srca   = ALUSRCA_PC;
    alu_srcb   = ALUSRCB_B;
    alu_ctrl   = ALU_ADD;
    retire     = 1'b0;
    case (state)
      FETCH: begin
        req      = 1'b1;
        alu_srcb = ALUSRCB_FOUR;
        if (mem_ready) begin
          ir_en      = 1'b1;
          pc_en      = 1'b1;
          next_state = DECODE;
        end
      end
      DECODE: begin
        ab_en     = 1'b1;
        alu_srcb  = ALUSRCB_IMMSL2;
        aluout_en = 1'b1;
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = funct_legal(funct) ? EXEC : HALT;
          OP_BEQ:       next_state = BRANCH;
`ifdef MC_CORE_EXT_EN
          OP_ADDI:      next_state = ADDIEX;
          OP_BNE:       next_state = BRANCH;
          OP_J:         next_state = JUMP;
`endif
          default:      next_state = HALT;
        endcase
      end
      MEMADR: begin
        alu_srca   = ALUSRCA_A;
        alu_srcb   = ALUSRCB_IMM;
        aluout_en  = 1'b1;
        next_state = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        req  = 1'b1;
        iord = 1'b1;
        if (mem_ready) begin
          data_en    = 1'b1;
          next_state = MEMWB;
        end
      end
      MEMWB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        next_state = FETCH;
      end
      MEMWR: begin
        req  = 1'b1;
        we   = 1'b1;
        iord = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          next_state = FETCH;
        end
      end
      EXEC: begin
        alu_srca   = ALUSRCA_A;
        alu_ctrl   = funct_alu(funct);
        aluout_en  = 1'b1;
        next_state = ALUWB;
      end
      ALUWB: begin
        reg_we     = 1'b1;
        reg_dst    = 1'b1;
        retire     = 1'b1;
        next_state = FETCH;
      end
      BRANCH: begin
        alu_srca   = ALUSRCA_A;
        alu_ctrl   = ALU_SUB;
        pc_src     = PCSRC_ALUOUT;
`ifdef MC_CORE_EXT_EN
        pc_en      = (op == OP_BNE) ? ~zero : zero;
`else
        pc_en      = zero;
`endif
        retire     = 1'b1;
        next_state = FETCH;
      end
`ifdef MC_CORE_EXT_EN
      ADDIEX: begin
        alu_srca   = ALUSRCA_A;
        alu_srcb   = ALUSRCB_IMM;
        aluout_en  = 1'b1;
        next_state = ADDIWB;
      end
      ADDIWB: begin
        reg_we     = 1'b1;
        retire     = 1'b1;
        next_state = FETCH;
      end
      JUMP: begin
        pc_src     = PCSRC_JUMP;
        pc_en      = 1'b1;
        retire     = 1'b1;
        next_state = FETCH;
      end
`endif
      HALT:    next_state = HALT;
      default: next_state = FETCH;
    endcase
    // Reset kills any in-flight request immediately, not at the next edge.
    mem_req = req & reset;
    mem_we  = we & reset;
  end

  assign halted = (state == HALT);

endmodule

// File: rtl/mc_core.sv
// mc_core: multi-cycle MIPS datapath with register file, ALU and an external req/ready memory port.
// Defining MC_CORE_EXT_EN enables addi, bne and j.
module mc_core
  import mc_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic                  halted,
  output logic [31:0]           retired,
  output logic [31:0]           pc_out
);

  logic [31:0] pc, ir, a, b, aluout, data;
  logic [31:0] rf [0:31];
  logic [31:0] signimm, srca, srcb, alu_y, pc_next, rd1, rd2, wd, addr_full;
  logic [4:0]  wa;
  logic        zero;

  logic       iord, ir_en, pc_en, ab_en, aluout_en, data_en;
  logic       reg_we, reg_dst, mem_to_reg, alu_srca;
  logic [1:0] pc_src, alu_srcb;
  logic       retire;
  alu_ctrl_t  alu_ctrl;

  mc_core_ctrl u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .op         (ir[31:26]),
    .funct      (ir[5:0]),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_en      (ir_en),
    .pc_en      (pc_en),
    .ab_en      (ab_en),
    .aluout_en  (aluout_en),
    .data_en    (data_en),
    .reg_we     (reg_we),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .pc_src     (pc_src),
    .alu_srca   (alu_srca),
    .alu_srcb   (alu_srcb),
    .alu_ctrl   (alu_ctrl),
    .retire     (retire),
    .halted     (halted)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      aluout  <= '0;
      data    <= '0;
      retired <= '0;
    end else begin
      if (pc_en)     pc      <= pc_next;
      if (ir_en)     ir      <= mem_rdata;
      if (ab_en)     a       <= rd1;
      if (ab_en)     b       <= rd2;
      if (aluout_en) aluout  <= alu_y;
      if (data_en)   data    <= mem_rdata;
      if (retire)    retired <= retired + 32'd1;
    end
  end

  // r0 is never written and always reads back as zero.
  always_ff @(posedge clk) begin
    if (reg_we && wa != 5'd0) rf[wa] <= wd;
  end

  assign rd1     = (ir[25:21] == 5'd0) ? 32'd0 : rf[ir[25:21]];
  assign rd2     = (ir[20:16] == 5'd0) ? 32'd0 : rf[ir[20:16]];
  assign wa      = reg_dst ? ir[15:11] : ir[20:16];
  assign wd      = mem_to_reg ? data : aluout;
  assign signimm = {{16{ir[15]}}, ir[15:0]};
  assign srca    = (alu_srca == ALUSRCA_A) ? a : pc;

  always_comb begin
    srcb = b;
    case (alu_srcb)
      ALUSRCB_FOUR:   srcb = 32'd4;
      ALUSRCB_IMM:    srcb = signimm;
      ALUSRCB_IMMSL2: srcb = {signimm[29:0], 2'b00};
      default:        srcb = b;
    endcase
  end

  always_comb begin
    alu_y = srca + srcb;
    case (alu_ctrl)
      ALU_AND: alu_y = srca & srcb;
      ALU_OR:  alu_y = srca | srcb;
      ALU_SUB: alu_y = srca - srcb;
      ALU_SLT: alu_y = {31'd0, $signed(srca) < $signed(srcb)};
      default: alu_y = srca + srcb;
    endcase
  end

  assign zero = (alu_y == 32'd0);

  always_comb begin
    pc_next = alu_y;
    case (pc_src)
      PCSRC_ALUOUT: pc_next = aluout;
      PCSRC_JUMP:   pc_next = {pc[31:28], ir[25:0], 2'b00};
      default:      pc_next = alu_y;
    endcase
  end

  // Data addresses are word-aligned by forcing the two low bits to zero.
  assign addr_full = iord ? aluout : pc;
  assign mem_addr  = addr_full[ADDR_WIDTH-1:0] & {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
  assign mem_wdata = b;
  assign pc_out    = pc;

endmodule

// File: tb/tb_mc_core.sv
// Self-checking bench for mc_core: ALU vector table over a lw/lw/op/sw program, plus branch, halt,
// reset-during-store and MC_CORE_EXT_EN sequences; memory accesses are checked against a scoreboard queue.
`timescale 1ns/1ps
module tb_mc_core;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          ADDR_WIDTH = 32;

  localparam logic [5:0] T_LW = 6'h23, T_SW = 6'h2B, T_BEQ = 6'h04, T_BNE = 6'h05, T_ADDI = 6'h08, T_J = 6'h02;
  localparam logic [5:0] T_ADD = 6'h20, T_SUB = 6'h22, T_AND = 6'h24, T_OR = 6'h25, T_SLT = 6'h2A;
  localparam logic [31:0] ILLEGAL = 32'hFC00_0000;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  mem_req, mem_we, halted;
  logic                  mem_ready = 1'b0;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata, retired, pc_out;
  logic [31:0]           mem_rdata = 32'h0;

  mc_core #(.RESET_PC(RESET_PC), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .halted    (halted),
    .retired   (retired),
    .pc_out    (pc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } access_t;

  typedef struct {
    string       name;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expected;
    bit          waits;
  } vec_t;

  logic [31:0] mem [0:63];
  access_t     expQ[$];
  int          vecCount = 0;
  int          missCount = 0;
  bit          randWaits = 1'b0;
  bit          stallWrites = 1'b0;
  bit          inWait = 1'b0;
  int          waitsLeft = 0;
  int          waitsInserted = 0;
  logic [31:0] holdAddr, holdWdata;
  logic        holdWe;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input logic we, input logic [31:0] addr, input logic [31:0] data);
    access_t e;
    e.we = we;
    e.addr = addr;
    e.data = data;
    expQ.push_back(e);
  endtask

  function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] encR(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                       input logic [5:0] funct);
    return {6'b0, rs, rt, rd, 5'b0, funct};
  endfunction

  // Each accepted access is popped from the scoreboard and compared before the memory acts on it.
  task automatic acceptAccess();
    access_t e;
    if (expQ.size() == 0) begin
      vecCount++;
      missCount++;
      $display("[TB] FAIL unexpected access: got we=%0b addr %h, expected none", mem_we, mem_addr);
    end else begin
      e = expQ.pop_front();
      checkOutput("access addr", mem_addr, e.addr);
      checkOutput("access we", {31'b0, mem_we}, {31'b0, e.we});
      if (e.we) checkOutput("store data", mem_wdata, e.data);
    end
    if (mem_we) mem[mem_addr[7:2]] = mem_wdata;
    else        mem_rdata = mem[mem_addr[7:2]];
  endtask

  // Memory model: decides ready on the falling edge so the DUT samples it on the next rising edge.
  always @(negedge clk) begin
    mem_ready = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    if (mem_req === 1'b1) begin
      if (inWait) begin
        checkOutput("wait addr stable", mem_addr, holdAddr);
        checkOutput("wait we stable", {31'b0, mem_we}, {31'b0, holdWe});
        if (holdWe) checkOutput("wait wdata stable", mem_wdata, holdWdata);
      end
      if (waitsLeft > 0 || (stallWrites && mem_we === 1'b1)) begin
        if (waitsLeft > 0) waitsLeft--;
        waitsInserted++;
        inWait    = 1'b1;
        holdAddr  = mem_addr;
        holdWe    = mem_we;
        holdWdata = mem_wdata;
      end else begin
        inWait    = 1'b0;
        mem_ready = 1'b1;
        acceptAccess();
        waitsLeft = randWaits ? int'($urandom_range(0, 3)) : 0;
      end
    end else begin
      inWait = 1'b0;
    end
  end

  task automatic startReset();
    reset         = 1'b0;
    randWaits     = 1'b0;
    stallWrites   = 1'b0;
    waitsLeft     = 0;
    waitsInserted = 0;
    inWait        = 1'b0;
    expQ.delete();
    repeat (2) @(posedge clk);
  endtask

  task automatic clearMem();
    for (int i = 0; i < 64; i++) mem[i] = ILLEGAL;
  endtask

  task automatic releaseReset();
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic runUntilRetired(input logic [31:0] target, input int budget, output int cycles);
    cycles = 0;
    while (retired !== target && cycles < budget) begin
      @(posedge clk);
      #1 cycles++;
    end
    if (retired !== target) begin
      vecCount++;
      missCount++;
      $display("[TB] FAIL retire timeout: got retired %h, expected %h", retired, target);
    end
  endtask

  task automatic runUntilHalted(input int budget);
    int cycles = 0;
    while (halted !== 1'b1 && cycles < budget) begin
      @(posedge clk);
      #1 cycles++;
    end
    checkOutput("halted reached", {31'b0, halted}, 32'd1);
  endtask

  task automatic checkHaltedIdle(input string tag, input logic [31:0] expRetired, input logic [31:0] expPc);
    repeat (4) begin
      @(negedge clk);
      checkOutput({tag, " halt mem_req"}, {31'b0, mem_req}, 32'd0);
    end
    checkOutput({tag, " halt retired"}, retired, expRetired);
    checkOutput({tag, " halt pc_out"}, pc_out, expPc);
    checkOutput({tag, " queue drained"}, expQ.size(), 32'd0);
  endtask

  // lw r1,0x40(r0); lw r2,0x44(r0); <op> r3,r1,r2; sw r3,0x48(r0)
  task automatic applyStimulus(input vec_t v);
    int cycles;
    startReset();
    clearMem();
    mem[0]  = encI(T_LW, 5'd0, 5'd1, 16'h0040);
    mem[1]  = encI(T_LW, 5'd0, 5'd2, 16'h0044);
    mem[2]  = encR(5'd1, 5'd2, 5'd3, v.funct);
    mem[3]  = encI(T_SW, 5'd0, 5'd3, 16'h0048);
    mem[16] = v.a;
    mem[17] = v.b;
    mem[18] = 32'h0;
    pushExp(1'b0, 32'h00, 32'h0);
    pushExp(1'b0, 32'h40, 32'h0);
    pushExp(1'b0, 32'h04, 32'h0);
    pushExp(1'b0, 32'h44, 32'h0);
    pushExp(1'b0, 32'h08, 32'h0);
    pushExp(1'b0, 32'h0C, 32'h0);
    pushExp(1'b1, 32'h48, v.expected);
    randWaits = v.waits;
    waitsLeft = v.waits ? int'($urandom_range(0, 3)) : 0;
    releaseReset();
    runUntilRetired(32'd4, 300, cycles);
    reset = 1'b0;
    checkOutput({v.name, " cycles"}, cycles, 32'd18 + waitsInserted);
    checkOutput({v.name, " mem[0x48]"}, mem[18], v.expected);
    checkOutput({v.name, " queue drained"}, expQ.size(), 32'd0);
  endtask

  // lw r1; lw r2; beq r1,r2,+2; sw r1,0x48; illegal; sw r2,0x4C; illegal
  task automatic branchSequence(input bit taken, input bit waits);
    startReset();
    clearMem();
    mem[0]  = encI(T_LW, 5'd0, 5'd1, 16'h0040);
    mem[1]  = encI(T_LW, 5'd0, 5'd2, 16'h0044);
    mem[2]  = encI(T_BEQ, 5'd1, 5'd2, 16'd2);
    mem[3]  = encI(T_SW, 5'd0, 5'd1, 16'h0048);
    mem[5]  = encI(T_SW, 5'd0, 5'd2, 16'h004C);
    mem[16] = 32'd9;
    mem[17] = taken ? 32'd9 : 32'd8;
    pushExp(1'b0, 32'h00, 32'h0);
    pushExp(1'b0, 32'h40, 32'h0);
    pushExp(1'b0, 32'h04, 32'h0);
    pushExp(1'b0, 32'h44, 32'h0);
    pushExp(1'b0, 32'h08, 32'h0);
    if (taken) begin
      pushExp(1'b0, 32'h14, 32'h0);
      pushExp(1'b1, 32'h4C, 32'd9);
      pushExp(1'b0, 32'h18, 32'h0);
    end else begin
      pushExp(1'b0, 32'h0C, 32'h0);
      pushExp(1'b1, 32'h48, 32'd9);
      pushExp(1'b0, 32'h10, 32'h0);
    end
    randWaits = waits;
    releaseReset();
    runUntilHalted(200);
    checkHaltedIdle(taken ? "beq taken" : "beq not taken", 32'd4, taken ? 32'h1C : 32'h14);
  endtask

  // Reset lands while the store sits in MEMWR waiting for ready.
  task automatic resetDuringStore();
    int cycles = 0;
    startReset();
    clearMem();
    mem[0]  = encI(T_LW, 5'd0, 5'd1, 16'h0040);
    mem[1]  = encI(T_SW, 5'd0, 5'd1, 16'h0048);
    mem[16] = 32'h0000_A5A5;
    mem[18] = 32'h0000_1111;
    pushExp(1'b0, 32'h00, 32'h0);
    pushExp(1'b0, 32'h40, 32'h0);
    pushExp(1'b0, 32'h04, 32'h0);
    stallWrites = 1'b1;
    releaseReset();
    while (!(mem_req === 1'b1 && mem_we === 1'b1) && cycles < 50) begin
      @(posedge clk);
      #1 cycles++;
    end
    checkOutput("store pending", {31'b0, mem_we}, 32'd1);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("reset drops mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("reset drops mem_we", {31'b0, mem_we}, 32'd0);
    checkOutput("reset queue drained", expQ.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset pc_out", pc_out, RESET_PC);
    checkOutput("reset retired", retired, 32'd1 - 32'd1);
    checkOutput("abandoned store mem", mem[18], 32'h0000_1111);
    stallWrites = 1'b0;
    pushExp(1'b0, RESET_PC, 32'h0);
    releaseReset();
    cycles = 0;
    while (expQ.size() != 0 && cycles < 20) begin
      @(posedge clk);
      #1 cycles++;
    end
    reset = 1'b0;
    checkOutput("refetch at RESET_PC", expQ.size(), 32'd0);
    checkOutput("store never landed", mem[18], 32'h0000_1111);
  endtask

  // addi r1,r0,-1; bne r1,r0,+1; j 0x40; sw r1,0x48(r0); illegal
  task automatic extensionSequence();
    startReset();
    clearMem();
    mem[0]  = encI(T_ADDI, 5'd0, 5'd1, 16'hFFFF);
    mem[1]  = encI(T_BNE, 5'd1, 5'd0, 16'd1);
    mem[2]  = {T_J, 26'h000_0010};
    mem[3]  = encI(T_SW, 5'd0, 5'd1, 16'h0048);
    mem[18] = 32'h0;
    pushExp(1'b0, 32'h00, 32'h0);
`ifdef MC_CORE_EXT_EN
    pushExp(1'b0, 32'h04, 32'h0);
    pushExp(1'b0, 32'h0C, 32'h0);
    pushExp(1'b1, 32'h48, 32'hFFFF_FFFF);
    pushExp(1'b0, 32'h10, 32'h0);
`endif
    releaseReset();
    runUntilHalted(100);
`ifdef MC_CORE_EXT_EN
    checkHaltedIdle("ext", 32'd3, 32'h14);
    checkOutput("ext r1 stored", mem[18], 32'hFFFF_FFFF);
`else
    checkHaltedIdle("no ext", 32'd0, 32'h04);
    checkOutput("no ext mem untouched", mem[18], 32'h0);
`endif
  endtask

  initial begin
    vec_t vecs[9];
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[9];
    vecs[0] = '{"add zero-wait",   T_ADD, 32'd5,         32'd7,         32'd12,        1'b0};
    vecs[1] = '{"add random-wait", T_ADD, 32'd5,         32'd7,         32'd12,        1'b1};
    vecs[2] = '{"sub negative",    T_SUB, 32'd3,         32'd10,        32'hFFFF_FFF9, 1'b0};
    vecs[3] = '{"and",             T_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0};
    vecs[4] = '{"or",              T_OR,  32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b1};
    vecs[5] = '{"slt -1<1",        T_SLT, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0};
    vecs[6] = '{"slt 1<-1",        T_SLT, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b1};
    vecs[7] = '{"add wrap",        T_ADD, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1};
    vecs[8] = '{"slt min<max",     T_SLT, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1,         1'b0};

    clearMem();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("reset mem_we", {31'b0, mem_we}, 32'd0);
    checkOutput("reset mem_addr", mem_addr, RESET_PC);
    checkOutput("reset mem_wdata", mem_wdata, 32'd0);
    checkOutput("reset halted", {31'b0, halted}, 32'd0);
    checkOutput("reset retired", retired, 32'd0);
    checkOutput("reset pc_out", pc_out, RESET_PC);

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

    branchSequence(1'b1, 1'b0);
    branchSequence(1'b0, 1'b0);
    branchSequence(1'b1, 1'b1);
    resetDuringStore();
    extensionSequence();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
